// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, MEM port, interrupt/vector signals, RAM port and
// boot status. Only clk and rst_n stay outside the bundle.
//   slave  : view taken by the arbiter (requests and ram_rdata in; grants, data, RAM drive out)
//   master : view taken by the surrounding pipeline and RAM
interface mem_arb_if;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic       if_rvalid;
    logic [7:0] if_rdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_gnt;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic       fetch_stall;
    logic       mem_stall;
    logic       intr;
    logic       vec_valid;
    logic [7:0] vec_pc;
    logic       vec_is_intr;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       boot_done;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, intr, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               fetch_stall, mem_stall, vec_valid, vec_pc, vec_is_intr,
               ram_en, ram_we, ram_addr, ram_wdata, boot_done
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, intr, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               fetch_stall, mem_stall, vec_valid, vec_pc, vec_is_intr,
               ram_en, ram_we, ram_addr, ram_wdata, boot_done
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one single-port synchronous RAM (1-cycle read latency) between the fetch
// stage and the MEM stage, and loads the reset vector (RAM[0x00]) after reset and the
// interrupt vector (RAM[0x01]) on an interrupt.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arb_if.slave (fetch/MEM request ports, stalls, intr, vector output, RAM port)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a 2-bit fetch starvation counter
// that forces a fetch grant after three consecutive denied fetch cycles.
module mem_arb (
    input  logic      clk,
    input  logic      rst_n,
    mem_arb_if.slave  bus
);

    typedef enum logic [2:0] {StBootRd, StBootWt, StRun, StIntRd, StIntWt} state_e;

    state_e     state_q, state_d;
    logic       intr_q;
    logic       intr_pend_q, intr_pend_d;
    logic       boot_done_q;
    logic       if_rvalid_q;
    logic       mem_rvalid_q;
    logic       enter_int;
    logic       starved;

    logic       if_gnt, mem_gnt, fetch_stall, mem_stall;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic       vec_valid, vec_is_intr;
    logic [7:0] vec_pc;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [1:0] starve_q;

    assign starved = (starve_q == 2'd3);

    // Counts RUN cycles in which a fetch request was refused; cleared by any fetch grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 2'd0;
        end else if (state_q == StRun) begin
            if (if_gnt) begin
                starve_q <= 2'd0;
            end else if (bus.if_req) begin
                starve_q <= starve_q + 2'd1;
            end
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        enter_int   = 1'b0;
        if_gnt      = 1'b0;
        mem_gnt     = 1'b0;
        fetch_stall = 1'b0;
        mem_stall   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = 8'h00;
        ram_wdata   = 8'h00;
        vec_valid   = 1'b0;
        vec_is_intr = 1'b0;
        vec_pc      = 8'h00;
        // Outputs are decoded only out of reset so that asserting rst_n clears them at once.
        if (rst_n) begin
            unique case (state_q)
                StBootRd: begin
                    ram_en  = 1'b1;
                    state_d = StBootWt;
                end
                StBootWt: begin
                    vec_valid = 1'b1;
                    vec_pc    = bus.ram_rdata;
                    state_d   = StRun;
                end
                StRun: begin
                    if (bus.if_req && (!bus.mem_req || starved)) begin
                        if_gnt = 1'b1;
                    end else if (bus.mem_req) begin
                        mem_gnt = 1'b1;
                    end
                    if (mem_gnt) begin
                        ram_en    = 1'b1;
                        ram_we    = bus.mem_we;
                        ram_addr  = bus.mem_addr;
                        ram_wdata = bus.mem_wdata;
                    end else if (if_gnt) begin
                        ram_en   = 1'b1;
                        ram_addr = bus.if_addr;
                    end
                    // Never leave with a MEM request still waiting for its grant.
                    if (intr_pend_q && (!bus.mem_req || mem_gnt)) begin
                        state_d   = StIntRd;
                        enter_int = 1'b1;
                    end
                end
                StIntRd: begin
                    ram_en   = 1'b1;
                    ram_addr = 8'h01;
                    state_d  = StIntWt;
                end
                StIntWt: begin
                    vec_valid   = 1'b1;
                    vec_is_intr = 1'b1;
                    vec_pc      = bus.ram_rdata;
                    state_d     = StRun;
                end
                default: state_d = StBootRd;
            endcase
            fetch_stall = bus.if_req & ~if_gnt;
            mem_stall   = bus.mem_req & ~mem_gnt;
        end
        // A new edge wins over the clear, so an edge in the entry cycle is serviced later.
        intr_pend_d = (bus.intr & ~intr_q) | (intr_pend_q & ~enter_int);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBootRd;
            intr_q       <= 1'b0;
            intr_pend_q  <= 1'b0;
            boot_done_q  <= 1'b0;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            intr_q       <= bus.intr;
            intr_pend_q  <= intr_pend_d;
            if (state_q == StBootWt) begin
                boot_done_q <= 1'b1;
            end
            if_rvalid_q  <= if_gnt;
            mem_rvalid_q <= mem_gnt & ~bus.mem_we;
        end
    end

    assign bus.if_gnt      = if_gnt;
    assign bus.mem_gnt     = mem_gnt;
    assign bus.fetch_stall = fetch_stall;
    assign bus.mem_stall   = mem_stall;
    assign bus.ram_en      = ram_en;
    assign bus.ram_we      = ram_we;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wdata   = ram_wdata;
    assign bus.vec_valid   = vec_valid;
    assign bus.vec_pc      = vec_pc;
    assign bus.vec_is_intr = vec_is_intr;
    assign bus.if_rvalid   = if_rvalid_q;
    assign bus.mem_rvalid  = mem_rvalid_q;
    // RAM output register holds the read data during the cycle after the grant.
    assign bus.if_rdata    = if_rvalid_q ? bus.ram_rdata : 8'h00;
    assign bus.mem_rdata   = mem_rvalid_q ? bus.ram_rdata : 8'h00;
    // Also high in the cycle the reset vector is presented.
    assign bus.boot_done   = boot_done_q | (state_q == StBootWt);

endmodule

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
module tb_mem_arb;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_arb_if bus ();

    mem_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM device (samples its port at the falling edge) ----------------
    logic [7:0] ram [256];
    logic       s_en, s_we;
    logic [7:0] s_addr, s_wdata;

    always @(negedge clk) begin
        s_en    = bus.ram_en;
        s_we    = bus.ram_we;
        s_addr  = bus.ram_addr;
        s_wdata = bus.ram_wdata;
    end

    always @(posedge clk) begin
        if (s_en) begin
            if (s_we) ram[s_addr] = s_wdata;
            else      bus.ram_rdata = ram[s_addr];
        end
    end

    // ---------------- behavioural model ----------------
    // phase: 2 = vector fetch cycle, 1 = vector delivery cycle, 0 = serving requests
    logic [7:0] exp_mem [256];
    int         phase;
    bit         vec_kind, booted, pend, intr_prev;
    int         starve;
    bit         pend_if_rv, pend_mem_rv;
    logic [7:0] pend_if_data, pend_mem_data;
    bit         d_fetch, d_mem;

    always @(negedge clk) begin
        bit         fw, mw, een, ewe;
        logic [7:0] ea, ewd;
        fw = 1'b0; mw = 1'b0; een = 1'b0; ewe = 1'b0; ea = 8'h00; ewd = 8'h00;
        if (!rst_n) begin
            chk1("rst_if_gnt", bus.if_gnt, 1'b0);
            chk1("rst_mem_gnt", bus.mem_gnt, 1'b0);
            chk1("rst_fetch_stall", bus.fetch_stall, 1'b0);
            chk1("rst_mem_stall", bus.mem_stall, 1'b0);
            chk1("rst_ram_en", bus.ram_en, 1'b0);
            chk1("rst_vec_valid", bus.vec_valid, 1'b0);
            chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
            chk1("rst_mem_rvalid", bus.mem_rvalid, 1'b0);
            chk1("rst_boot_done", bus.boot_done, 1'b0);
        end else begin
            if (phase == 2) begin
                een = 1'b1;
                ea  = vec_kind ? 8'h01 : 8'h00;
            end else if (phase == 0) begin
                fw = bus.if_req && (!bus.mem_req || (Guard && starve == 3));
                mw = bus.mem_req && !fw;
                if (mw) begin
                    een = 1'b1; ewe = bus.mem_we; ea = bus.mem_addr; ewd = bus.mem_wdata;
                end else if (fw) begin
                    een = 1'b1; ea = bus.if_addr;
                end
            end
            chk1("if_gnt", bus.if_gnt, fw);
            chk1("mem_gnt", bus.mem_gnt, mw);
            chk1("fetch_stall", bus.fetch_stall, bus.if_req && !fw);
            chk1("mem_stall", bus.mem_stall, bus.mem_req && !mw);
            chk1("ram_en", bus.ram_en, een);
            if (een) begin
                chk8("ram_addr", bus.ram_addr, ea);
                chk1("ram_we", bus.ram_we, ewe);
                if (ewe) chk8("ram_wdata", bus.ram_wdata, ewd);
            end
            chk1("vec_valid", bus.vec_valid, phase == 1);
            if (phase == 1) begin
                chk8("vec_pc", bus.vec_pc, exp_mem[vec_kind ? 8'h01 : 8'h00]);
                chk1("vec_is_intr", bus.vec_is_intr, vec_kind);
            end
            chk1("boot_done", bus.boot_done, booted || phase == 1);
            chk1("if_rvalid", bus.if_rvalid, pend_if_rv);
            if (pend_if_rv) chk8("if_rdata", bus.if_rdata, pend_if_data);
            chk1("mem_rvalid", bus.mem_rvalid, pend_mem_rv);
            if (pend_mem_rv) chk8("mem_rdata", bus.mem_rdata, pend_mem_data);
        end
        d_fetch = fw;
        d_mem   = mw;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 2; vec_kind = 1'b0; booted = 1'b0; pend = 1'b0; intr_prev = 1'b0;
            starve = 0; pend_if_rv = 1'b0; pend_mem_rv = 1'b0; d_fetch = 1'b0; d_mem = 1'b0;
        end else begin
            bit rise;
            rise      = bus.intr && !intr_prev;
            intr_prev = bus.intr;
            pend_if_rv = d_fetch;
            if (d_fetch) pend_if_data = exp_mem[bus.if_addr];
            pend_mem_rv = d_mem && !bus.mem_we;
            if (pend_mem_rv) pend_mem_data = exp_mem[bus.mem_addr];
            if (d_mem && bus.mem_we) exp_mem[bus.mem_addr] = bus.mem_wdata;
            if (phase == 2) begin
                phase = 1;
            end else if (phase == 1) begin
                phase = 0;
                booted = 1'b1;
            end else begin
                if (d_fetch) starve = 0;
                else if (bus.if_req) starve++;
                if (pend && (!bus.mem_req || d_mem)) begin
                    phase = 2; vec_kind = 1'b1; pend = 1'b0;
                end
            end
            if (rise) pend = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req = 1'b0; bus.if_addr = 8'h00; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        bus.mem_addr = 8'h00; bus.mem_wdata = 8'h00; bus.intr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram[a] = v;
            exp_mem[a] = v;
        end
        ram[8'h00] = 8'h40; exp_mem[8'h00] = 8'h40;
        ram[8'h01] = 8'h77; exp_mem[8'h01] = 8'h77;
        ram[8'h41] = 8'h9C; exp_mem[8'h41] = 8'h9C;
        ram[8'h90] = 8'hA5; exp_mem[8'h90] = 8'hA5;

        // Requests pending during reset must not raise stalls.
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.mem_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_fetch_stall", bus.fetch_stall, 1'b0);
        chk1("reset_ram_en", bus.ram_en, 1'b0);
        idle();
        rst_n = 1'b1;

        // Boot sequence
        @(negedge clk);
        chk1("boot_rd_en", bus.ram_en, 1'b1);
        chk8("boot_rd_addr", bus.ram_addr, 8'h00);
        step();
        @(negedge clk);
        chk1("boot_vec_valid", bus.vec_valid, 1'b1);
        chk8("boot_vec_pc", bus.vec_pc, 8'h40);
        chk1("boot_vec_is_intr", bus.vec_is_intr, 1'b0);
        chk1("boot_done_set", bus.boot_done, 1'b1);

        // Fetch read
        step();
        bus.if_req = 1'b1; bus.if_addr = 8'h41;
        @(negedge clk);
        chk1("fetch_gnt", bus.if_gnt, 1'b1);
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk1("fetch_rvalid", bus.if_rvalid, 1'b1);
        chk8("fetch_rdata", bus.if_rdata, 8'h9C);

        // MEM write beats a simultaneous fetch
        step();
        bus.if_req = 1'b1; bus.if_addr = 8'h42;
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 8'h80; bus.mem_wdata = 8'h55;
        @(negedge clk);
        chk1("conflict_mem_gnt", bus.mem_gnt, 1'b1);
        chk1("conflict_fetch_stall", bus.fetch_stall, 1'b1);
        chk1("conflict_if_gnt", bus.if_gnt, 1'b0);
        step();
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        @(negedge clk);
        chk1("deferred_fetch_gnt", bus.if_gnt, 1'b1);
        chk8("ram_write_80", ram[8'h80], 8'h55);
        step();
        bus.if_req = 1'b0;

        // Starvation: fetch and MEM both held for five cycles
        step();
        bus.if_req = 1'b1; bus.if_addr = 8'h20;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 8'h10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk1("starve_if_gnt", bus.if_gnt, Guard && c == 4);
            chk1("starve_mem_stall", bus.mem_stall, Guard && c == 4);
            step();
        end
        idle();

        // Interrupt during a MEM read
        bus.mem_req = 1'b1; bus.mem_addr = 8'h90; bus.intr = 1'b1;
        @(negedge clk);
        chk1("intr_mem_gnt", bus.mem_gnt, 1'b1);
        step();
        bus.mem_req = 1'b0; bus.intr = 1'b0;
        @(negedge clk);
        chk1("intr_mem_rvalid", bus.mem_rvalid, 1'b1);
        chk8("intr_mem_rdata", bus.mem_rdata, 8'hA5);
        step();
        @(negedge clk);
        chk1("int_rd_en", bus.ram_en, 1'b1);
        chk8("int_rd_addr", bus.ram_addr, 8'h01);
        step();
        @(negedge clk);
        chk1("int_vec_valid", bus.vec_valid, 1'b1);
        chk1("int_vec_is_intr", bus.vec_is_intr, 1'b1);
        chk8("int_vec_pc", bus.vec_pc, 8'h77);
        step();

        // Randomized traffic; addresses 0x00/0x01 kept intact for the reboot check
        for (int i = 0; i < 600; i++) begin
            bus.if_req    = ($urandom_range(0, 2) != 0);
            bus.if_addr   = 8'($urandom);
            bus.mem_req   = ($urandom_range(0, 1) != 0);
            bus.mem_we    = ($urandom_range(0, 1) != 0);
            bus.mem_addr  = 8'($urandom_range(2, 255));
            bus.mem_wdata = 8'($urandom);
            bus.intr      = ($urandom_range(0, 9) == 0);
            step();
        end

        // Drain, then reset during INT_WT with a second interrupt pending
        idle();
        repeat (8) step();
        bus.intr = 1'b1;
        step();
        bus.intr = 1'b0;
        step();
        bus.intr = 1'b1;
        step();
        @(negedge clk);
        chk1("pre_reset_int_wt", bus.vec_valid && bus.vec_is_intr, 1'b1);
        #1;
        rst_n = 1'b0;
        bus.intr = 1'b0; bus.if_req = 1'b1; bus.mem_req = 1'b1;
        #1;
        chk1("async_vec_valid", bus.vec_valid, 1'b0);
        chk1("async_ram_en", bus.ram_en, 1'b0);
        chk1("async_fetch_stall", bus.fetch_stall, 1'b0);
        chk1("async_mem_stall", bus.mem_stall, 1'b0);
        chk1("async_boot_done", bus.boot_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk8("reboot_rd_addr", bus.ram_addr, 8'h00);
        chk1("reboot_rd_en", bus.ram_en, 1'b1);
        step();
        @(negedge clk);
        chk8("reboot_vec_pc", bus.vec_pc, 8'h40);
        chk1("reboot_vec_is_intr", bus.vec_is_intr, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            chk1("lost_intr_no_vec", bus.vec_valid, 1'b0);
            chk1("lost_intr_no_ram", bus.ram_en, 1'b0);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
